// File: rtl/coerencia_pkg.sv
// Shared definitions for the coherence memory subsystem: widths, cache-line
// states, bus messages and main-memory FSM states.
package coerencia_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned N_WORDS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // MSI cache-line states
  typedef enum logic [1:0] {
    INVALIDO      = 2'd0,
    MODIFICADO    = 2'd1,
    COMPARTILHADO = 2'd2
  } estado_cache_t;

  // Snooping bus messages
  typedef enum logic [2:0] {
    BUS_NADA   = 3'd0,
    BUS_RD     = 3'd1,
    BUS_RDX    = 3'd2,
    BUS_INV    = 3'd3,
    BUS_WB     = 3'd4
  } msg_bus_t;

  // Main-memory read FSM
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } estado_mem_t;

  // One write-back buffer entry
  typedef struct packed {
    addr_t addr;
    data_t data;
  } wb_entry_t;

endpackage

// File: rtl/memoria_principal_fila_wb.sv
// Write-back FIFO in front of the memory array. Exposes the live entries in
// age order (index 0 = head/oldest) so reads can forward pending data.
module fila_wb
  import coerencia_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  wb_entry_t                      din_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output wb_entry_t                      head_o,
  output wb_entry_t [DEPTH-1:0]          view_o,
  output logic [DEPTH-1:0]               view_vld_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  wb_entry_t [DEPTH-1:0] ent_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = ent_q[head_q];

  // A full buffer still accepts a push when the head leaves on the same edge
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Age-ordered view of the buffer, wrapping from head
  always_comb begin
    int unsigned idx;
    view_o     = '0;
    view_vld_o = '0;
    idx        = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = 32'(head_q) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      view_o[i]     = ent_q[idx[PW-1:0]];
      view_vld_o[i] = (CW'(i) < count_q);
    end
  end

  // Pointer and occupancy bookkeeping, pointers wrap modulo DEPTH
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ent_q   <= '0;
    end else begin
      if (do_push) begin
        ent_q[tail_q] <= din_i;
        tail_q        <= (tail_q == PW'(DEPTH-1)) ? '0 : tail_q + 1'b1;
      end
      if (do_pop) begin
        head_q <= (head_q == PW'(DEPTH-1)) ? '0 : head_q + 1'b1;
      end
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/memoria_principal.sv
// Main memory: 8x3 array behind a write-back buffer, with a fixed-latency
// read port. Read data is resolved when the read is sampled and delivered
// LAT_READ edges later with a one-cycle mem_valid strobe.
module memoria_principal
  import coerencia_pkg::*;
#(
  parameter int unsigned LAT_READ = 2,
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              WB,
  input  logic [ADDR_W-1:0] enderecoWB,
  input  logic [DATA_W-1:0] dadoWB,
  input  logic              read,
  input  logic [ADDR_W-1:0] enderecoMem,
  output logic [DATA_W-1:0] dadoMem,
  output logic              mem_valid,
  output logic              busy,
  output logic              wb_full,
  output logic              overflow
);

  localparam int unsigned CW = $clog2(WB_DEPTH+1);

  estado_mem_t              state_q;
  logic [2:0]               cnt_q;
  data_t                    resp_q;
  data_t                    dado_q;
  logic                     valid_q;
  logic                     ovf_q;
  data_t                    mem_q [N_WORDS];

  logic                     fifo_full, fifo_empty, pop;
  logic [CW-1:0]            fifo_count;
  wb_entry_t                fifo_head;
  wb_entry_t [WB_DEPTH-1:0] fifo_view;
  logic [WB_DEPTH-1:0]      fifo_vld;
  data_t                    fwd_d;
  logic                     drop;

  fila_wb #(.DEPTH(WB_DEPTH)) u_fila (
    .clock      (clock),
    .resetn     (resetn),
    .push_i     (WB),
    .pop_i      (pop),
    .din_i      ({enderecoWB, dadoWB}),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_o     (fifo_head),
    .view_o     (fifo_view),
    .view_vld_o (fifo_vld)
  );

  assign pop       = (state_q == MEM_IDLE) && !fifo_empty;
  assign drop      = WB && fifo_full && !pop;
  assign wb_full   = (fifo_count == CW'(WB_DEPTH));
  assign busy      = (state_q != MEM_IDLE);
  assign dadoMem   = dado_q;
  assign mem_valid = valid_q;
  assign overflow  = ovf_q;

  // Newest value wins: array, then buffer oldest-to-newest, then same-edge WB.
  // The entry being drained this edge is still visible in the buffer view.
  always_comb begin
    fwd_d = mem_q[enderecoMem];
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (fifo_vld[i] && fifo_view[i].addr == enderecoMem) fwd_d = fifo_view[i].data;
    end
    if (WB && enderecoWB == enderecoMem) fwd_d = dadoWB;
  end

  // Read FSM, registered outputs, array drain and sticky error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      dado_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < N_WORDS; i++) mem_q[i] <= data_t'(i);
    end else begin
      valid_q <= 1'b0;
      if (pop)  mem_q[fifo_head.addr] <= fifo_head.data;
      if (drop) ovf_q <= 1'b1;
      case (state_q)
        MEM_IDLE: begin
          if (read) begin
            resp_q <= fwd_d;
            if (LAT_READ == 1) begin
              state_q <= MEM_RESP;
            end else begin
              state_q <= MEM_WAIT;
              cnt_q   <= 3'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (read) ovf_q <= 1'b1;
          if (cnt_q == 3'(LAT_READ-1)) state_q <= MEM_RESP;
          else                         cnt_q   <= cnt_q + 3'd1;
        end
        MEM_RESP: begin
          if (read) ovf_q <= 1'b1;
          state_q <= MEM_IDLE;
          cnt_q   <= '0;
          dado_q  <= resp_q;
          valid_q <= 1'b1;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

endmodule
